mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter that shares the core's one external memory port among three line-sized requesters: I-cache refill, D-cache refill, and D-cache/victim-cache writeback. It sits between the cache miss handlers and the memory interface. It grants one requester at a time and drives the address handshake. It counts burst beats, steers read data and write data, and pulses completion back to the granted requester.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, beat width
- LINE_WORDS, 4, beats per burst (power of 2, ≥2)
- STARVE_LIMIT, 8, wait cycles before I-cache is promoted to top priority
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ic_req / dc_req / wb_req  in  1 each  request; held until matching *_done
- ic_addr / dc_addr / wb_addr  in  ADDR_WIDTH each  miss/victim address; sampled at grant
- wb_wdata  in  DATA_WIDTH  current writeback beat
- wb_wnext  out  1  writeback beat accepted; requester advances to next beat
- ic_rvalid / dc_rvalid  out  1 each  read beat valid for that requester
- ic_rdata / dc_rdata  out  DATA_WIDTH each  mirror of mem_rdata
- ic_done / dc_done / wb_done  out  1 each  one-cycle completion pulse
- mem_req_valid  out  1  / mem_req_ready  in  1  address handshake
- mem_req_addr  out  ADDR_WIDTH  line-aligned burst address
- mem_req_write  out  1  1 = write burst
- mem_wvalid  out  1  / mem_wready  in  1  / mem_wdata  out  DATA_WIDTH  write beats
- mem_rvalid  in  1  / mem_rdata  in  DATA_WIDTH  read beats (no backpressure)
- grant  out  2  0 none, 1 IC, 2 DC, 3 WB
- protocol_err  out  1  sticky; set on unexpected mem_rvalid

## Operation
- FSM states: IDLE, ADDR, RDATA, WDATA, DONE.
- IDLE: arbitrate among asserted requests and register the winner into grant. Capture the address with its low log2(LINE_WORDS)+2 bits zeroed. Go to ADDR. With no request, stay in IDLE with grant=0.
- Priority: WB > DC > IC. If starve_cnt==STARVE_LIMIT, IC is top priority, above WB.
- starve_cnt: increments, saturating at STARVE_LIMIT, each cycle ic_req=1 and grant≠IC. Clears to 0 on the cycle IC is granted and on rst.
- ADDR: mem_req_valid=1, mem_req_write=(grant==WB). The address is held until mem_req_ready=1. Then go to WDATA if WB, otherwise RDATA. Clear beat_cnt.
- RDATA: each mem_rvalid increments beat_cnt. The granted requester's *_rvalid = mem_rvalid, combinationally. On the beat where beat_cnt==LINE_WORDS-1, go to DONE.
- WDATA: mem_wvalid=1, mem_wdata=wb_wdata. On mem_wvalid&&mem_wready: wb_wnext=1 and beat_cnt increments. The last beat goes to DONE.
- DONE: the granted requester's *_done=1 for exactly one cycle, then IDLE with grant=0. A requester still asserting req in the following IDLE is treated as a new request.
- beat_cnt is log2(LINE_WORDS) bits and wraps to 0 after the last beat.
- mem_rvalid in any state other than RDATA sets protocol_err. That beat is dropped and forwarded to no one. protocol_err clears only on rst.
- Requests changing while granted have no effect until the next IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, grant 0, beat_cnt 0, starve_cnt 0, protocol_err 0.
- Request seen in IDLE at cycle N gives mem_req_valid=1 at N+1 (registered grant, 1-cycle arbitration latency).
- With mem_req_ready=1 at N+1: data phase starts N+2. Minimum read burst: done pulse at N+2+LINE_WORDS, IDLE at N+3+LINE_WORDS.
- *_rvalid, *_rdata, wb_wnext and mem_wdata are combinational from memory inputs and state. All other outputs are registered state decodes.
- Simultaneous requests and a starvation saturation in the same cycle: saturation is evaluated on the registered starve_cnt value, so it affects arbitration from the next IDLE.
- rst mid-burst: FSM returns to IDLE next edge and all outputs drop. No done pulse is issued. The in-flight memory burst is abandoned, and the memory side is reset with the core.

## Test plan
- Single DC read, addr 0x1004, ready immediate, 4 beats 0xA0..0xA3 -> mem_req_addr=0x1000, dc_rvalid on 4 beats with matching data, dc_done one cycle after 4th beat, ic_rvalid stays 0.
- WB write, ready stalls 2 cycles in ADDR and mem_wready low on beat 2 -> mem_req_write=1, wb_wnext exactly 4 pulses, wb_done once, mem_wvalid held during stall.
- ic_req, dc_req and wb_req all asserted in the same cycle -> grant order WB, DC, IC, with no overlapping bursts.
- ic_req held while WB/DC alternate continuously, STARVE_LIMIT=8 -> IC granted at the first IDLE after starve_cnt reaches 8 even with wb_req=1, then starve_cnt=0.
- mem_rvalid pulsed in IDLE -> protocol_err=1 and stays set, no *_rvalid. rst clears it.
- rst asserted on beat 2 of an IC read -> next cycle state IDLE, grant=0, no ic_done. A fresh dc_req afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one external burst memory port among I-cache refill, D-cache refill and writeback.
// One requester is granted at a time; beats are counted and data is steered to or from it.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LINE_WORDS   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic                  dc_req,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  wb_wnext,
  output logic                  ic_rvalid,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  ic_done,
  output logic                  dc_done,
  output logic                  wb_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_write,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            grant,
  output logic                  protocol_err
);

  localparam int unsigned BeatW   = $clog2(LINE_WORDS);
  localparam int unsigned OffW    = BeatW + 2;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] GrNone = 2'd0;
  localparam logic [1:0] GrIc   = 2'd1;
  localparam logic [1:0] GrDc   = 2'd2;
  localparam logic [1:0] GrWb   = 2'd3;

  localparam logic [BeatW-1:0]   LastBeat   = BeatW'(LINE_WORDS - 1);
  localparam logic [StarveW-1:0] StarveSat  = StarveW'(STARVE_LIMIT);

  typedef enum logic [2:0] {StIdle, StAddr, StRdata, StWdata, StDone} state_e;

  state_e                state_q;
  logic [1:0]            grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BeatW-1:0]      beat_q;
  logic [StarveW-1:0]    starve_q;
  logic                  perr_q;

  logic [1:0]            win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  unused_addr_bits;

  // A saturated starvation count lifts IC above even a pending writeback.
  always_comb begin
    win = GrNone;
    if (ic_req && starve_q == StarveSat) win = GrIc;
    else if (wb_req)                     win = GrWb;
    else if (dc_req)                     win = GrDc;
    else if (ic_req)                     win = GrIc;
  end

  always_comb begin
    win_addr = ic_addr;
    if (win == GrDc) win_addr = dc_addr;
    if (win == GrWb) win_addr = wb_addr;
  end

  assign unused_addr_bits = ^win_addr[OffW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= GrNone;
      addr_q   <= '0;
      beat_q   <= '0;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      if (mem_rvalid && state_q != StRdata) perr_q <= 1'b1;

      if (state_q == StIdle && win == GrIc) begin
        starve_q <= '0;
      end else if (ic_req && grant_q != GrIc && starve_q != StarveSat) begin
        starve_q <= starve_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (win != GrNone) begin
            grant_q <= win;
            addr_q  <= {win_addr[ADDR_WIDTH-1:OffW], OffW'(0)};
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (mem_req_ready) begin
            beat_q  <= '0;
            state_q <= (grant_q == GrWb) ? StWdata : StRdata;
          end
        end
        StRdata: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StDone;
          end
        end
        StWdata: begin
          if (mem_wready) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= StDone;
          end
        end
        StDone: begin
          grant_q <= GrNone;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic rd_beat;
  assign rd_beat = (state_q == StRdata) && mem_rvalid;

  assign mem_req_valid = (state_q == StAddr);
  assign mem_req_write = (state_q == StAddr) && (grant_q == GrWb);
  assign mem_req_addr  = addr_q;
  assign mem_wvalid    = (state_q == StWdata);
  assign mem_wdata     = mem_wvalid ? wb_wdata : '0;
  assign wb_wnext      = mem_wvalid && mem_wready;

  assign ic_rvalid = rd_beat && (grant_q == GrIc);
  assign dc_rvalid = rd_beat && (grant_q == GrDc);
  assign ic_rdata  = mem_rdata;
  assign dc_rdata  = mem_rdata;

  assign ic_done = (state_q == StDone) && (grant_q == GrIc);
  assign dc_done = (state_q == StDone) && (grant_q == GrDc);
  assign wb_done = (state_q == StDone) && (grant_q == GrWb);

  assign grant        = grant_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, writes, priority, starvation, protocol error, reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, dc_req, wb_req;
  logic [31:0] ic_addr, dc_addr, wb_addr, wb_wdata;
  logic        wb_wnext, ic_rvalid, dc_rvalid;
  logic [31:0] ic_rdata, dc_rdata;
  logic        ic_done, dc_done, wb_done;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr;
  logic        mem_wvalid, mem_wready;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;
  logic        protocol_err;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .dc_req(dc_req), .wb_req(wb_req),
    .ic_addr(ic_addr), .dc_addr(dc_addr), .wb_addr(wb_addr),
    .wb_wdata(wb_wdata), .wb_wnext(wb_wnext),
    .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
    .ic_rdata(ic_rdata), .dc_rdata(dc_rdata),
    .ic_done(ic_done), .dc_done(dc_done), .wb_done(wb_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .grant(grant), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the ADDR cycle; returns in the IDLE cycle after the done pulse.
  task automatic run_read(input logic [1:0] g, input logic [31:0] a, input logic [31:0] base,
                          input int stall);
    check("rd_grant", grant, g);
    check("rd_addr", mem_req_addr, a);
    check("rd_write", mem_req_write, 1'b0);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      tick();
      check("rd_addr_hold", {mem_req_valid, mem_req_addr}, {1'b1, a});
    end
    check("rd_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(i);
      #1;
      check("rd_rvalid", {ic_rvalid, dc_rvalid}, (g == 2'd1) ? 2'b10 : 2'b01);
      check("rd_rdata", (g == 2'd1) ? ic_rdata : dc_rdata, base + 32'(i));
      check("rd_early_done", {ic_done, dc_done, wb_done}, 3'b000);
      tick();
    end
    mem_rvalid = 1'b0;
    check("rd_done", {ic_done, dc_done, wb_done}, (g == 2'd1) ? 3'b100 : 3'b010);
    if (g == 2'd1) ic_req = 1'b0;
    else dc_req = 1'b0;
    tick();
    check("rd_done_once", {ic_done, dc_done, wb_done}, 3'b000);
    check("rd_back_idle", grant, 2'd0);
  endtask

  task automatic run_write(input logic [31:0] a, input int stall, input int low_beat);
    int  beats, wnexts, cyc;
    bit  stalled;
    check("wr_grant", grant, 2'd3);
    check("wr_addr", mem_req_addr, a);
    check("wr_write", mem_req_write, 1'b1);
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0;
      tick();
      check("wr_addr_hold", {mem_req_valid, mem_req_write, mem_req_addr}, {2'b11, a});
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    beats = 0; wnexts = 0; cyc = 0; stalled = 0;
    while (beats < 4 && cyc < 20) begin
      wb_wdata   = 32'hB000_0000 + 32'(beats);
      mem_wready = !(beats == low_beat && !stalled);
      #1;
      check("wr_wvalid", mem_wvalid, 1'b1);
      check("wr_wdata", mem_wdata, 32'hB000_0000 + 32'(beats));
      check("wr_wnext", wb_wnext, (beats == low_beat && !stalled) ? 1'b0 : 1'b1);
      if (wb_wnext) wnexts++;
      if (mem_wready) beats++;
      else stalled = 1;
      tick();
      cyc++;
    end
    mem_wready = 1'b0;
    check("wr_wnext_count", wnexts, 4);
    check("wr_done", {ic_done, dc_done, wb_done}, 3'b001);
    wb_req = 1'b0;
    tick();
    check("wr_done_once", {ic_done, dc_done, wb_done}, 3'b000);
    check("wr_back_idle", grant, 2'd0);
  endtask

  initial begin
    rst = 1'b1;
    {ic_req, dc_req, wb_req} = 3'b000;
    ic_addr = '0; dc_addr = '0; wb_addr = '0; wb_wdata = '0;
    mem_req_ready = 1'b0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("rst_outputs",
          {grant, mem_req_valid, mem_req_write, mem_wvalid, ic_done, dc_done, wb_done,
           protocol_err, wb_wnext, ic_rvalid, dc_rvalid}, '0);
    check("rst_addr", mem_req_addr, 32'h0);
    rst = 1'b0;
    tick();

    // Single DC read, immediate ready
    dc_req = 1'b1; dc_addr = 32'h1004;
    #1;
    check("idle_no_valid", mem_req_valid, 1'b0);
    tick();
    run_read(2'd2, 32'h1000, 32'hA0, 0);

    // WB write with address stall and a wready gap
    wb_req = 1'b1; wb_addr = 32'h4018;
    tick();
    run_write(32'h4010, 2, 2);

    // All three at once: WB, DC, IC
    wb_req = 1'b1; dc_req = 1'b1; ic_req = 1'b1;
    wb_addr = 32'h5000; dc_addr = 32'h6024; ic_addr = 32'h2ABC;
    tick();
    run_write(32'h5000, 0, -1);
    tick();
    run_read(2'd2, 32'h6020, 32'hC0, 0);
    tick();
    run_read(2'd1, 32'h2AB0, 32'hD0, 1);

    // Starvation: IC waits through two WB bursts, then beats a pending WB
    ic_req = 1'b1; dc_req = 1'b1; wb_req = 1'b1;
    tick();
    run_write(32'h5000, 0, -1);
    wb_req = 1'b1;
    tick();
    run_write(32'h5000, 0, -1);
    wb_req = 1'b1;
    tick();
    check("starve_ic_wins", grant, 2'd1);
    wb_req = 1'b1;
    run_read(2'd1, 32'h2AB0, 32'hE0, 0);
    // Counter cleared: WB wins again over IC
    ic_req = 1'b1;
    tick();
    check("starve_cleared", grant, 2'd3);
    run_write(32'h5000, 0, -1);
    tick();
    run_read(2'd2, 32'h6020, 32'hF0, 0);
    tick();
    run_read(2'd1, 32'h2AB0, 32'h10, 0);

    // Stray read beat in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    #1;
    check("perr_no_fwd", {ic_rvalid, dc_rvalid}, 2'b00);
    tick();
    mem_rvalid = 1'b0;
    check("perr_set", protocol_err, 1'b1);
    tick();
    tick();
    check("perr_sticky", {protocol_err, grant}, {1'b1, 2'd0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perr_rst", protocol_err, 1'b0);

    // Reset on beat 2 of an IC read
    ic_req = 1'b1; ic_addr = 32'h7000;
    tick();
    check("abort_grant", grant, 2'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 32'h30 + 32'(i);
      tick();
    end
    mem_rvalid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid = 1'b0; ic_req = 1'b0;
    check("abort_idle", {grant, mem_req_valid, ic_done, ic_rvalid, protocol_err}, '0);
    tick();
    check("abort_no_done", {ic_done, mem_req_valid, grant}, '0);
    dc_req = 1'b1; dc_addr = 32'h300C;
    tick();
    run_read(2'd2, 32'h3000, 32'h40, 0);
    check("final_perr", protocol_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
